// File: rtl/tm_pkg.sv
// Shared definitions for the Turing machine datapath.
//   - head move encoding (MOVE_STAY / MOVE_LEFT / MOVE_RIGHT, 2'b11 reserved)
//   - tape unit FSM state type (IDLE, SETTLE, FAULT)
//   - default symbol width and blank symbol value
//   - decode_move(): folds the reserved encoding onto MOVE_STAY
package tm_pkg;

  localparam logic [1:0] MOVE_STAY  = 2'b00;
  localparam logic [1:0] MOVE_LEFT  = 2'b01;
  localparam logic [1:0] MOVE_RIGHT = 2'b10;

  localparam int DEFAULT_SYMBOL_WIDTH = 2;
  localparam int DEFAULT_BLANK        = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    FAULT  = 2'd2
  } tape_state_t;

  // The reserved move code behaves exactly like "stay".
  function automatic logic [1:0] decode_move(input logic [1:0] move);
    decode_move = (move == MOVE_LEFT || move == MOVE_RIGHT) ? move : MOVE_STAY;
  endfunction

endpackage

// File: rtl/tape_unit_if.sv
// Step-command / symbol-result bus between the transition logic and the tape.
//   master (transition logic): drives cmd_valid, cmd_write, cmd_symbol, cmd_move;
//                              observes cmd_ready, symbol, symbol_valid.
//   slave  (tape_unit):        the mirror image.
interface tape_unit_if
  import tm_pkg::*;
#(
  parameter int SYMBOL_WIDTH = DEFAULT_SYMBOL_WIDTH
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [SYMBOL_WIDTH-1:0] cmd_symbol;
  logic [1:0]              cmd_move;
  logic [SYMBOL_WIDTH-1:0] symbol;
  logic                    symbol_valid;

  modport master (
    output cmd_valid, cmd_write, cmd_symbol, cmd_move,
    input  cmd_ready, symbol, symbol_valid
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_symbol, cmd_move,
    output cmd_ready, symbol, symbol_valid
  );
endinterface

// File: rtl/tape_mem.sv
// Tape cell storage: TAPE_DEPTH x SYMBOL_WIDTH register array.
// Every cell returns to BLANK on a synchronous reset, so this is a flop array
// rather than a RAM. One write port, one asynchronous read port.
//   clk, reset  clock and synchronous active-high reset
//   we_i        write strobe
//   waddr_i     write cell index
//   wdata_i     write data
//   raddr_i     read cell index (the head)
//   rdata_o     combinational read data
module tape_mem
  import tm_pkg::*;
#(
  parameter  int SYMBOL_WIDTH = DEFAULT_SYMBOL_WIDTH,
  parameter  int TAPE_DEPTH   = 64,
  parameter  int BLANK        = DEFAULT_BLANK,
  localparam int AW           = $clog2(TAPE_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we_i,
  input  logic [AW-1:0]           waddr_i,
  input  logic [SYMBOL_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]           raddr_i,
  output logic [SYMBOL_WIDTH-1:0] rdata_o
);

  logic [SYMBOL_WIDTH-1:0] cells_q [TAPE_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPE_DEPTH; i++) begin
        cells_q[i] <= SYMBOL_WIDTH'(BLANK);
      end
    end else if (we_i) begin
      cells_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = cells_q[raddr_i];

endmodule

// File: rtl/tape_unit.sv
// Tape storage and read/write head for the Turing machine datapath.
// Accepts one step command (optional write at the head, then move) every two
// cycles and presents the registered symbol under the head.
//   clk, reset                 clock, synchronous active-high reset
//   load_en/addr/symbol        preload write port, honoured only in IDLE and
//                              dropped when a command handshake coincides
//   bus (tape_unit_if.slave)   step command in, symbol/symbol_valid out
//   head_pos                   current head index
//   fault                      sticky: a move tried to leave the tape
// Optional build macro TAPE_WRAP_EN: circular tape, fault tied low and the
// FAULT state unreachable.
module tape_unit
  import tm_pkg::*;
#(
  parameter  int SYMBOL_WIDTH = DEFAULT_SYMBOL_WIDTH,
  parameter  int TAPE_DEPTH   = 64,
  parameter  int HEAD_INIT    = 32,
  parameter  int BLANK        = DEFAULT_BLANK,
  localparam int AW           = $clog2(TAPE_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_en,
  input  logic [AW-1:0]           load_addr,
  input  logic [SYMBOL_WIDTH-1:0] load_symbol,
  tape_unit_if.slave              bus,
  output logic [AW-1:0]           head_pos,
  output logic                    fault
);

  tape_state_t             state_q, state_d;
  logic [AW-1:0]           head_q, head_d;
  logic [SYMBOL_WIDTH-1:0] symbol_q;
  logic                    symbol_valid_q;

  logic                    handshake;
  logic                    off_tape;
  logic [1:0]              move;
  logic                    cmd_ready;
  logic                    mem_we;
  logic [AW-1:0]           mem_waddr;
  logic [SYMBOL_WIDTH-1:0] mem_wdata;
  logic [SYMBOL_WIDTH-1:0] mem_rdata;

  assign move      = decode_move(bus.cmd_move);
  assign handshake = bus.cmd_valid && (state_q == IDLE);

`ifdef TAPE_WRAP_EN
  // AW-bit head arithmetic wraps naturally on a power-of-two tape.
  assign off_tape = 1'b0;
`else
  assign off_tape = ((move == MOVE_LEFT)  && (head_q == '0)) ||
                    ((move == MOVE_RIGHT) && (head_q == AW'(TAPE_DEPTH - 1)));
`endif

  tape_mem #(
    .SYMBOL_WIDTH (SYMBOL_WIDTH),
    .TAPE_DEPTH   (TAPE_DEPTH),
    .BLANK        (BLANK)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (head_q),
    .rdata_o (mem_rdata)
  );

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      head_q         <= AW'(HEAD_INIT);
      symbol_q       <= SYMBOL_WIDTH'(BLANK);
      symbol_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      symbol_valid_q <= (state_q == SETTLE);
      // Outside FAULT the symbol follows the head cell every cycle; in SETTLE
      // the head already points at the new cell, so this is the step result.
      if (state_q != FAULT) begin
        symbol_q <= mem_rdata;
      end
    end
  end

  // Next-state and head update.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          if (off_tape) begin
            state_d = FAULT;
          end else begin
            state_d = SETTLE;
            if (move == MOVE_LEFT)  head_d = head_q - AW'(1);
            if (move == MOVE_RIGHT) head_d = head_q + AW'(1);
          end
        end
      end
      SETTLE:  state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ready and the tape write-port mux (command beats preload).
  always_comb begin
    cmd_ready = (state_q == IDLE);
    mem_we    = 1'b0;
    mem_waddr = head_q;
    mem_wdata = bus.cmd_symbol;
    if (handshake) begin
      mem_we = bus.cmd_write;
    end else if (load_en && (state_q == IDLE)) begin
      mem_we    = 1'b1;
      mem_waddr = load_addr;
      mem_wdata = load_symbol;
    end
  end

  assign bus.cmd_ready    = cmd_ready;
  assign bus.symbol       = symbol_q;
  assign bus.symbol_valid = symbol_valid_q;
  assign head_pos         = head_q;

`ifdef TAPE_WRAP_EN
  assign fault = 1'b0;
`else
  logic fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (handshake && off_tape) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`endif

endmodule

// File: tb/tb_tape_unit.sv
// Self-checking bench for tape_unit: a per-cycle vector table for the main
// step/preload behaviour, plus hand-written sequences for tape edges and
// reset during a step. Build with TAPE_WRAP_EN to check the circular tape.
module tb_tape_unit;
  import tm_pkg::*;

  localparam int SW = 2;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [SW-1:0] load_symbol;
  logic [AW-1:0] head_pos;
  logic          fault;

  int checks = 0;
  int errors = 0;

  tape_unit_if #(.SYMBOL_WIDTH(SW)) bus ();

  tape_unit #(
    .SYMBOL_WIDTH (SW),
    .TAPE_DEPTH   (64),
    .HEAD_INIT    (32),
    .BLANK        (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_symbol (load_symbol),
    .bus         (bus),
    .head_pos    (head_pos),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [SW-1:0] load_sym;
    logic          cmd_valid;
    logic          cmd_write;
    logic [SW-1:0] cmd_sym;
    logic [1:0]    cmd_move;
    logic          exp_ready;
    logic [AW-1:0] exp_head;
    logic [SW-1:0] exp_sym;
    logic          exp_valid;
  } vec_t;

  vec_t vecs [23];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    load_en        = 1'b0;
    load_addr      = '0;
    load_symbol    = '0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_symbol = '0;
    bus.cmd_move   = MOVE_STAY;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // One complete step from IDLE; waits (bounded) for the result pulse.
  task automatic step(input logic [1:0] mv, input logic wr, input logic [SW-1:0] sy);
    int n;
    bus.cmd_valid  = 1'b1;
    bus.cmd_write  = wr;
    bus.cmd_symbol = sy;
    bus.cmd_move   = mv;
    cyc();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    n = 0;
    while (!bus.symbol_valid && n < 4) begin
      cyc();
      n++;
    end
    chk("step_result_seen", int'(bus.symbol_valid), 1);
  endtask

  initial begin
    int bad;

    //            ld  addr sym  cv  cw  cs  move        rdy head sym vld
    vecs[0]  = '{1'b0, 6'd0,  2'd0, 1'b0, 1'b0, 2'd0, MOVE_STAY,  1'b1, 6'd32, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 6'd0,  2'd0, 1'b0, 1'b0, 2'd0, MOVE_STAY,  1'b1, 6'd32, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 6'd0,  2'd0, 1'b0, 1'b0, 2'd0, MOVE_STAY,  1'b1, 6'd32, 2'd0, 1'b0};
    vecs[3]  = '{1'b1, 6'd33, 2'd2, 1'b0, 1'b0, 2'd0, MOVE_STAY,  1'b1, 6'd32, 2'd0, 1'b0};
    vecs[4]  = '{1'b0, 6'd0,  2'd0, 1'b1, 1'b1, 2'd3, MOVE_RIGHT, 1'b0, 6'd33, 2'd0, 1'b0};
    vecs[5]  = '{1'b0, 6'd0,  2'd0, 1'b0, 1'b0, 2'd0, MOVE_STAY,  1'b1, 6'd33, 2'd2, 1'b1};
    vecs[6]  = '{1'b0, 6'd0,  2'd0, 1'b0, 1'b0, 2'd0, MOVE_STAY,  1'b1, 6'd33, 2'd2, 1'b0};
    // cmd_valid held for four left steps
    vecs[7]  = '{1'b0, 6'd0,  2'd0, 1'b1, 1'b0, 2'd0, MOVE_LEFT,  1'b0, 6'd32, 2'd2, 1'b0};
    vecs[8]  = '{1'b0, 6'd0,  2'd0, 1'b1, 1'b0, 2'd0, MOVE_LEFT,  1'b1, 6'd32, 2'd3, 1'b1};
    vecs[9]  = '{1'b0, 6'd0,  2'd0, 1'b1, 1'b0, 2'd0, MOVE_LEFT,  1'b0, 6'd31, 2'd3, 1'b0};
    vecs[10] = '{1'b0, 6'd0,  2'd0, 1'b1, 1'b0, 2'd0, MOVE_LEFT,  1'b1, 6'd31, 2'd0, 1'b1};
    vecs[11] = '{1'b0, 6'd0,  2'd0, 1'b1, 1'b0, 2'd0, MOVE_LEFT,  1'b0, 6'd30, 2'd0, 1'b0};
    vecs[12] = '{1'b0, 6'd0,  2'd0, 1'b1, 1'b0, 2'd0, MOVE_LEFT,  1'b1, 6'd30, 2'd0, 1'b1};
    vecs[13] = '{1'b0, 6'd0,  2'd0, 1'b1, 1'b0, 2'd0, MOVE_LEFT,  1'b0, 6'd29, 2'd0, 1'b0};
    vecs[14] = '{1'b0, 6'd0,  2'd0, 1'b1, 1'b0, 2'd0, MOVE_LEFT,  1'b1, 6'd29, 2'd0, 1'b1};
    vecs[15] = '{1'b0, 6'd0,  2'd0, 1'b0, 1'b0, 2'd0, MOVE_STAY,  1'b1, 6'd29, 2'd0, 1'b0};
    // preload coinciding with a reserved-move command: load dropped
    vecs[16] = '{1'b1, 6'd29, 2'd1, 1'b1, 1'b0, 2'd0, 2'b11,      1'b0, 6'd29, 2'd0, 1'b0};
    vecs[17] = '{1'b0, 6'd0,  2'd0, 1'b0, 1'b0, 2'd0, MOVE_STAY,  1'b1, 6'd29, 2'd0, 1'b1};
    vecs[18] = '{1'b0, 6'd0,  2'd0, 1'b0, 1'b0, 2'd0, MOVE_STAY,  1'b1, 6'd29, 2'd0, 1'b0};
    // stay with write
    vecs[19] = '{1'b0, 6'd0,  2'd0, 1'b1, 1'b1, 2'd1, MOVE_STAY,  1'b0, 6'd29, 2'd0, 1'b0};
    vecs[20] = '{1'b0, 6'd0,  2'd0, 1'b0, 1'b0, 2'd0, MOVE_STAY,  1'b1, 6'd29, 2'd1, 1'b1};
    // preload under the head shows up one cycle later
    vecs[21] = '{1'b1, 6'd29, 2'd2, 1'b0, 1'b0, 2'd0, MOVE_STAY,  1'b1, 6'd29, 2'd1, 1'b0};
    vecs[22] = '{1'b0, 6'd0,  2'd0, 1'b0, 1'b0, 2'd0, MOVE_STAY,  1'b1, 6'd29, 2'd2, 1'b0};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 23; i++) begin
      load_en        = vecs[i].load_en;
      load_addr      = vecs[i].load_addr;
      load_symbol    = vecs[i].load_sym;
      bus.cmd_valid  = vecs[i].cmd_valid;
      bus.cmd_write  = vecs[i].cmd_write;
      bus.cmd_symbol = vecs[i].cmd_sym;
      bus.cmd_move   = vecs[i].cmd_move;
      cyc();
      $display("vec %0d: rdy=%0d head=%0d sym=%0d vld=%0d fault=%0d", i,
               bus.cmd_ready, head_pos, bus.symbol, bus.symbol_valid, fault);
      chk($sformatf("v%0d_ready", i), int'(bus.cmd_ready), int'(vecs[i].exp_ready));
      chk($sformatf("v%0d_head", i), int'(head_pos), int'(vecs[i].exp_head));
      chk($sformatf("v%0d_symbol", i), int'(bus.symbol), int'(vecs[i].exp_sym));
      chk($sformatf("v%0d_valid", i), int'(bus.symbol_valid), int'(vecs[i].exp_valid));
      chk($sformatf("v%0d_fault", i), int'(fault), 0);
      if (i == 5) chk("cell32_written", int'(dut.u_mem.cells_q[32]), 3);
    end
    idle_inputs();

    // Left edge: preload cell 0, walk the head down, then step off the tape.
    do_reset();
    load_en = 1'b1; load_addr = 6'd0; load_symbol = 2'd1;
    cyc();
    idle_inputs();
    for (int i = 0; i < 32; i++) step(MOVE_LEFT, 1'b0, 2'd0);
    chk("left_walk_head", int'(head_pos), 0);
    chk("left_walk_symbol", int'(bus.symbol), 1);
    bus.cmd_valid = 1'b1; bus.cmd_move = MOVE_LEFT;
    cyc();
    idle_inputs();
`ifdef TAPE_WRAP_EN
    $display("left edge (wrap): head=%0d fault=%0d", head_pos, fault);
    chk("left_wrap_head", int'(head_pos), 63);
    chk("left_wrap_fault", int'(fault), 0);
    cyc();
    chk("left_wrap_valid", int'(bus.symbol_valid), 1);
    chk("left_wrap_symbol", int'(bus.symbol), 0);
`else
    $display("left edge: head=%0d fault=%0d rdy=%0d", head_pos, fault, bus.cmd_ready);
    chk("left_fault_set", int'(fault), 1);
    chk("left_fault_ready", int'(bus.cmd_ready), 0);
    chk("left_fault_head", int'(head_pos), 0);
    bus.cmd_valid = 1'b1; bus.cmd_move = MOVE_RIGHT;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("left_fault_sticky", int'(fault), 1);
      chk("left_fault_no_valid", int'(bus.symbol_valid), 0);
      chk("left_fault_hold_ready", int'(bus.cmd_ready), 0);
      chk("left_fault_hold_head", int'(head_pos), 0);
    end
    idle_inputs();
`endif
    chk("cell0_unchanged", int'(dut.u_mem.cells_q[0]), 1);

    // Right edge, with a write on the offending step.
    do_reset();
    chk("after_reset_fault", int'(fault), 0);
    chk("after_reset_ready", int'(bus.cmd_ready), 1);
    for (int i = 0; i < 31; i++) step(MOVE_RIGHT, 1'b0, 2'd0);
    chk("right_walk_head", int'(head_pos), 63);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_symbol = 2'd3;
    bus.cmd_move = MOVE_RIGHT;
    cyc();
    idle_inputs();
    $display("right edge: head=%0d fault=%0d cell63=%0d", head_pos, fault,
             dut.u_mem.cells_q[63]);
`ifdef TAPE_WRAP_EN
    chk("right_wrap_head", int'(head_pos), 0);
    chk("right_wrap_fault", int'(fault), 0);
`else
    chk("right_fault_head", int'(head_pos), 63);
    chk("right_fault_set", int'(fault), 1);
`endif
    chk("right_edge_write", int'(dut.u_mem.cells_q[63]), 3);

    // Reset arriving while a step is settling.
    do_reset();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_symbol = 2'd2;
    bus.cmd_move = MOVE_RIGHT;
    cyc();
    chk("settle_ready_low", int'(bus.cmd_ready), 0);
    chk("settle_cell32", int'(dut.u_mem.cells_q[32]), 2);
    idle_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    $display("reset in SETTLE: head=%0d vld=%0d rdy=%0d", head_pos,
             bus.symbol_valid, bus.cmd_ready);
    chk("rst_settle_head", int'(head_pos), 32);
    chk("rst_settle_valid", int'(bus.symbol_valid), 0);
    chk("rst_settle_ready", int'(bus.cmd_ready), 1);
    chk("rst_settle_symbol", int'(bus.symbol), 0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (dut.u_mem.cells_q[i] != 2'd0) bad++;
    chk("rst_settle_cells_blank", bad, 0);
    cyc();
    chk("rst_settle_no_pulse", int'(bus.symbol_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
